// File: rtl/calc_op_sched.sv
// Command sequencer for the calc_ops units: reads header + two operands from the input FIFO,
// starts the selected unit and pushes its one- or two-word result (or an error word) to the output FIFO.
module calc_op_sched #(
  parameter int                          RAH_PACKET_WIDTH = 48,
  parameter int                          NUM_UNITS        = 4,
  parameter int                          TIMEOUT_CYC      = 1024,
  parameter logic [RAH_PACKET_WIDTH-1:0] ERR_WORD         = 48'hEEEE_0000_0000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RAH_PACKET_WIDTH-1:0]           rd_data,
  input  logic                                  rd_empty,
  output logic                                  rd_en,
  output logic [RAH_PACKET_WIDTH-1:0]           wr_data,
  input  logic                                  wr_full,
  output logic                                  wr_en,
  output logic [RAH_PACKET_WIDTH-1:0]           op_a,
  output logic [RAH_PACKET_WIDTH-1:0]           op_b,
  output logic [NUM_UNITS-1:0]                  unit_start,
  input  logic [NUM_UNITS-1:0]                  unit_done,
  input  logic [NUM_UNITS-1:0]                  unit_two,
  input  logic [NUM_UNITS*2*RAH_PACKET_WIDTH-1:0] unit_res,
  output logic                                  busy,
  output logic                                  err,
  output logic [1:0]                            err_code,
  output logic [15:0]                           cmd_count
);

  localparam int W  = RAH_PACKET_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    IDLE, RD_HDR, RD_A, RD_B, START, WAIT, WR_HI, WR_LO, WR_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic                   rd_en_q, rd_en_d;
  logic                   pend_q, pend_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [W-1:0]           op_a_q, op_a_d;
  logic [W-1:0]           op_b_q, op_b_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2*W-1:0]         res_q, res_d;
  logic [1:0]             code_q, code_d;
  logic [NUM_UNITS-1:0]   unit_start_q, unit_start_d;
  logic                   wr_en_q, wr_en_d;
  logic [W-1:0]           wr_data_q, wr_data_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [15:0]            cmd_count_q, cmd_count_d;

  // Per-unit decode of the captured opcode; an opcode matching no unit is a bad opcode.
  logic [NUM_UNITS-1:0]   hit;
  logic [2*W-1:0]         res_slice [NUM_UNITS];
  logic [2*W-1:0]         res_sel;
  logic                   done_sel, two_sel;

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign hit[gi]       = (opcode_q == 8'(gi));
      assign res_slice[gi] = unit_res[gi*2*W +: 2*W];
    end
  endgenerate

  always_comb begin
    res_sel = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      res_sel = res_sel | (res_slice[k] & {(2*W){hit[k]}});
    end
  end

  assign done_sel = |(unit_done & hit);
  assign two_sel  = |(unit_two & hit);

  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    pend_d       = 1'b0;
    opcode_d     = opcode_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    timer_d      = timer_q;
    res_d        = res_q;
    code_d       = code_q;
    unit_start_d = '0;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    cmd_count_d  = cmd_count_q;

    case (state_q)
      IDLE: begin
        if (!rd_empty) begin
          rd_en_d = 1'b1;
          state_d = RD_HDR;
        end
      end
      RD_HDR, RD_A, RD_B: begin
        // rd_en cycle -> data cycle; empty is only trusted outside the pop cycle
        if (rd_en_q) begin
          pend_d = 1'b1;
        end else if (pend_q) begin
          case (state_q)
            RD_HDR: begin
              opcode_d = rd_data[W-1 -: 8];
              state_d  = RD_A;
              rd_en_d  = !rd_empty;
            end
            RD_A: begin
              op_a_d  = rd_data;
              state_d = RD_B;
              rd_en_d = !rd_empty;
            end
            default: begin
              op_b_d = rd_data;
              if (|hit) begin
                state_d = START;
              end else begin
                state_d = WR_ERR;
                code_d  = 2'd1;
              end
            end
          endcase
        end else begin
          rd_en_d = !rd_empty;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_sel) begin
          res_d   = res_sel;
          state_d = two_sel ? WR_HI : WR_LO;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = WR_ERR;
          code_d  = 2'd2;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WR_HI: begin
        if (wr_en_q) state_d = WR_LO;
      end
      WR_LO, WR_ERR: begin
        if (wr_en_q) begin
          state_d     = IDLE;
          cmd_count_d = cmd_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == START) unit_start_d = hit;

    // A push is issued on entry to (or while stalled in) a write state, never right after a push.
    if (!wr_en_q && !wr_full &&
        (state_d == WR_HI || state_d == WR_LO || state_d == WR_ERR)) begin
      wr_en_d = 1'b1;
      case (state_d)
        WR_HI:   wr_data_d = res_d[2*W-1:W];
        WR_LO:   wr_data_d = res_d[W-1:0];
        default: begin
          wr_data_d  = ERR_WORD | W'(code_d);
          err_d      = 1'b1;
          err_code_d = code_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      pend_q       <= 1'b0;
      opcode_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      timer_q      <= '0;
      res_q        <= '0;
      code_q       <= '0;
      unit_start_q <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      cmd_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      pend_q       <= pend_d;
      opcode_q     <= opcode_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      timer_q      <= timer_d;
      res_q        <= res_d;
      code_q       <= code_d;
      unit_start_q <= unit_start_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      cmd_count_q  <= cmd_count_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign unit_start = unit_start_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_calc_op_sched.sv
// Directed bench for calc_op_sched: FIFO models on the negative edge, unit pulses from the tests.
module tb_calc_op_sched;
  localparam int W  = 48;
  localparam int NU = 4;
  localparam int TO = 16;
  localparam logic [W-1:0] ERR1 = 48'hEEEE_0000_0001;
  localparam logic [W-1:0] ERR2 = 48'hEEEE_0000_0002;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] rd_data = '0;
  logic rd_empty = 1'b1;
  logic rd_en;
  logic [W-1:0] wr_data;
  logic wr_full = 1'b0;
  logic wr_en;
  logic [W-1:0] op_a, op_b;
  logic [NU-1:0] unit_start;
  logic [NU-1:0] unit_done = '0;
  logic [NU-1:0] unit_two = '0;
  logic [NU*2*W-1:0] unit_res = '0;
  logic busy, err;
  logic [1:0] err_code;
  logic [15:0] cmd_count;

  int total = 0;
  int bad = 0;

  calc_op_sched #(
    .RAH_PACKET_WIDTH(W), .NUM_UNITS(NU), .TIMEOUT_CYC(TO), .ERR_WORD(48'hEEEE_0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .rd_data(rd_data), .rd_empty(rd_empty), .rd_en(rd_en),
    .wr_data(wr_data), .wr_full(wr_full), .wr_en(wr_en), .op_a(op_a), .op_b(op_b),
    .unit_start(unit_start), .unit_done(unit_done), .unit_two(unit_two), .unit_res(unit_res),
    .busy(busy), .err(err), .err_code(err_code), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic full_seen = 1'b0, empty_seen = 1'b1;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    full_seen  <= wr_full;
    empty_seen <= rd_empty;
  end

  // FIFO models and monitors
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  int wr_cyc_q[$];
  logic [NU-1:0] start_log[$];
  int start_cyc = 0, vis_cyc = 0;
  logic [W-1:0] start_a = '0, start_b = '0;
  int pops = 0, pop_viol = 0, push_viol = 0, gap_viol = 0, err_cnt = 0, err_at_wr = 0;
  bit wr_prev = 1'b0, block_empty = 1'b0, bp_mode = 1'b0;

  always @(negedge clk) begin
    bit new_empty;
    if (rd_en) begin
      if (empty_seen) pop_viol++;
      if (in_q.size() > 0) rd_data = in_q.pop_front();
      pops++;
    end
    if (wr_en) begin
      if (full_seen) push_viol++;
      if (wr_prev) gap_viol++;
      out_q.push_back(wr_data);
      wr_cyc_q.push_back(cyc);
      if (err) err_at_wr++;
    end
    wr_prev = wr_en;
    if (err) err_cnt++;
    if (unit_start != '0) begin
      start_log.push_back(unit_start);
      start_cyc = cyc;
      start_a   = op_a;
      start_b   = op_b;
    end
    if (!bp_mode) block_empty = 1'b0;
    else if (cyc % 3 == 0) block_empty = !block_empty;
    new_empty = (in_q.size() == 0) || block_empty;
    if (rd_empty && !new_empty) vis_cyc = cyc;
    rd_empty = new_empty;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic [W-1:0] h, input logic [W-1:0] a, input logic [W-1:0] b);
    in_q.push_back(h);
    in_q.push_back(a);
    in_q.push_back(b);
  endtask

  task automatic wait_start(input int base, input int budget, output bit ok);
    int n = 0;
    while (start_log.size() <= base && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    ok = (start_log.size() > base);
  endtask

  task automatic wait_writes(input int want, input int budget, output bit ok);
    int n = 0;
    while (out_q.size() < want && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    ok = (out_q.size() >= want);
  endtask

  task automatic pulse_done(input int k, input bit two, input logic [2*W-1:0] res, output int dcyc);
    @(posedge clk);
    #2;
    unit_done[k] = 1'b1;
    unit_two[k]  = two;
    unit_res[k*2*W +: 2*W] = res;
    dcyc = cyc;
    @(posedge clk);
    #2;
    unit_done = '0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL reset_en: got rd=%b wr=%b want 0", rd_en, wr_en); end
    total++; if (unit_start !== '0) begin bad++; $display("FAIL reset_start: got %b want 0", unit_start); end
    total++; if (cmd_count !== 16'd0 || err_code !== 2'd0 || err !== 1'b0) begin bad++; $display("FAIL reset_cnt: got cnt=%0d code=%0d err=%b want 0", cmd_count, err_code, err); end
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_mul();
    int sb = start_log.size();
    int wb = out_q.size();
    int dcyc = 0;
    bit ok;
    push_cmd(48'h0200_0000_0000, 48'd3, 48'd5);
    wait_start(sb, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL mul_start_seen: got none want start"); end
    if (ok) begin
      total++; if (start_log[sb] !== 4'b0100) begin bad++; $display("FAIL mul_start: got %b want 0100", start_log[sb]); end
      total++; if (start_cyc - vis_cyc != 7) begin bad++; $display("FAIL mul_latency: got %0d want 7", start_cyc - vis_cyc); end
      total++; if (start_a !== 48'd3 || start_b !== 48'd5) begin bad++; $display("FAIL mul_ops: got a=%0h b=%0h want 3 5", start_a, start_b); end
    end
    wait_cycles(2);
    total++; if (busy !== 1'b1 || op_a !== 48'd3) begin bad++; $display("FAIL mul_wait: got busy=%b a=%0h want 1 3", busy, op_a); end
    pulse_done(2, 1'b1, {48'd0, 48'd15}, dcyc);
    wait_writes(wb + 2, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL mul_writes: got %0d want 2", out_q.size() - wb); end
    if (ok) begin
      total++; if (out_q[wb] !== 48'd0 || out_q[wb+1] !== 48'd15) begin bad++; $display("FAIL mul_data: got %0h %0h want 0 f", out_q[wb], out_q[wb+1]); end
      total++; if (wr_cyc_q[wb] - dcyc != 1) begin bad++; $display("FAIL mul_wr_latency: got %0d want 1", wr_cyc_q[wb] - dcyc); end
    end
    wait_cycles(2);
    total++; if (cmd_count !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL mul_count: got cnt=%0d busy=%b want 1 0", cmd_count, busy); end
    $display("mul: writes=%0d cmd_count=%0d", out_q.size() - wb, cmd_count);
  endtask

  task automatic test_add();
    int sb = start_log.size();
    int wb = out_q.size();
    int dcyc = 0;
    bit ok;
    push_cmd(48'h0000_0000_0000, 48'd7, 48'd9);
    wait_start(sb, 50, ok);
    total++; if (!ok || start_log[sb] !== 4'b0001) begin bad++; $display("FAIL add_start: got %b want 0001", ok ? start_log[sb] : 4'b0000); end
    pulse_done(0, 1'b0, {48'hFFFF, 48'd16}, dcyc);
    wait_writes(wb + 1, 30, ok);
    wait_cycles(4);
    total++; if (out_q.size() - wb != 1) begin bad++; $display("FAIL add_nwrites: got %0d want 1", out_q.size() - wb); end
    total++; if (!ok || out_q[wb] !== 48'd16) begin bad++; $display("FAIL add_data: got %0h want 10", ok ? out_q[wb] : 48'd0); end
    total++; if (start_log.size() - sb != 1) begin bad++; $display("FAIL add_nstarts: got %0d want 1", start_log.size() - sb); end
    total++; if (cmd_count !== 16'd2) begin bad++; $display("FAIL add_count: got %0d want 2", cmd_count); end
    $display("add: writes=%0d cmd_count=%0d", out_q.size() - wb, cmd_count);
  endtask

  task automatic test_bad_opcode();
    int sb = start_log.size();
    int wb = out_q.size();
    int p0 = pops, e0 = err_cnt, ew0 = err_at_wr;
    bit ok;
    push_cmd(48'h0700_0000_0000, 48'd1, 48'd2);
    wait_writes(wb + 1, 40, ok);
    wait_cycles(3);
    total++; if (!ok || out_q[wb] !== ERR1) begin bad++; $display("FAIL bad_data: got %0h want %0h", ok ? out_q[wb] : 48'd0, ERR1); end
    total++; if (start_log.size() != sb) begin bad++; $display("FAIL bad_nostart: got %0d want 0", start_log.size() - sb); end
    total++; if (pops - p0 != 3) begin bad++; $display("FAIL bad_pops: got %0d want 3", pops - p0); end
    total++; if (err_cnt - e0 != 1 || err_at_wr - ew0 != 1) begin bad++; $display("FAIL bad_err_pulse: got %0d/%0d want 1/1", err_cnt - e0, err_at_wr - ew0); end
    total++; if (err_code !== 2'd1 || cmd_count !== 16'd3) begin bad++; $display("FAIL bad_code: got code=%0d cnt=%0d want 1 3", err_code, cmd_count); end
    $display("bad_opcode: word=%0h err_code=%0d", ok ? out_q[wb] : 48'd0, err_code);
  endtask

  task automatic test_timeout();
    int sb = start_log.size();
    int wb = out_q.size();
    int dcyc = 0;
    bit ok;
    push_cmd(48'h0100_0000_0000, 48'd1, 48'd2);
    wait_start(sb, 50, ok);
    wait_writes(wb + 1, 60, ok);
    total++; if (!ok || out_q[wb] !== ERR2) begin bad++; $display("FAIL to_data: got %0h want %0h", ok ? out_q[wb] : 48'd0, ERR2); end
    total++; if (!ok || wr_cyc_q[wb] - start_cyc != 17) begin bad++; $display("FAIL to_latency: got %0d want 17", ok ? wr_cyc_q[wb] - start_cyc : -1); end
    wait_cycles(2);
    total++; if (err_code !== 2'd2 || cmd_count !== 16'd4) begin bad++; $display("FAIL to_code: got code=%0d cnt=%0d want 2 4", err_code, cmd_count); end
    pulse_done(1, 1'b1, {48'hDEAD, 48'hBEEF}, dcyc);
    wait_cycles(5);
    total++; if (out_q.size() - wb != 1 || busy !== 1'b0 || cmd_count !== 16'd4) begin bad++; $display("FAIL to_late_done: got writes=%0d busy=%b cnt=%0d want 1 0 4", out_q.size() - wb, busy, cmd_count); end
    sb = start_log.size();
    push_cmd(48'h0100_0000_0000, 48'd4, 48'd6);
    wait_start(sb, 50, ok);
    pulse_done(1, 1'b1, {48'd1, 48'd2}, dcyc);
    wait_writes(wb + 3, 30, ok);
    wait_cycles(2);
    total++; if (!ok || out_q[wb+1] !== 48'd1 || out_q[wb+2] !== 48'd2) begin bad++; $display("FAIL to_next_cmd: got writes=%0d want 1 then 2", out_q.size() - wb - 1); end
    total++; if (cmd_count !== 16'd5) begin bad++; $display("FAIL to_next_count: got %0d want 5", cmd_count); end
    $display("timeout: err_word=%0h next_cmd_ok=%b", out_q[wb], ok);
  endtask

  task automatic test_backpressure();
    int sb = start_log.size();
    int wb = out_q.size();
    int p0 = pops, pv0 = pop_viol, fv0 = push_viol, gv0 = gap_viol;
    int dcyc = 0;
    bit ok;
    bp_mode = 1'b1;
    push_cmd(48'h0200_0000_0000, 48'd8, 48'd9);
    wait_start(sb, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_start: got none want start"); end
    wr_full = 1'b1;
    pulse_done(2, 1'b1, {48'hABC, 48'h123}, dcyc);
    wait_cycles(10);
    total++; if (out_q.size() != wb || busy !== 1'b1) begin bad++; $display("FAIL bp_full_hold: got writes=%0d busy=%b want 0 1", out_q.size() - wb, busy); end
    wr_full = 1'b0;
    wait_writes(wb + 2, 30, ok);
    wait_cycles(2);
    total++; if (!ok || out_q[wb] !== 48'hABC || out_q[wb+1] !== 48'h123) begin bad++; $display("FAIL bp_data: got writes=%0d want abc then 123", out_q.size() - wb); end
    total++; if (pop_viol != pv0 || push_viol != fv0 || gap_viol != gv0) begin bad++; $display("FAIL bp_protocol: got pop=%0d push=%0d gap=%0d want 0", pop_viol - pv0, push_viol - fv0, gap_viol - gv0); end
    total++; if (pops - p0 != 3 || cmd_count !== 16'd6) begin bad++; $display("FAIL bp_count: got pops=%0d cnt=%0d want 3 6", pops - p0, cmd_count); end
    bp_mode = 1'b0;
    $display("backpressure: writes=%0d pops=%0d", out_q.size() - wb, pops - p0);
  endtask

  task automatic test_reset_in_wait();
    int sb = start_log.size();
    int wb;
    int dcyc = 0;
    bit ok;
    push_cmd(48'h0300_0000_0000, 48'd11, 48'd12);
    wait_start(sb, 50, ok);
    wait_cycles(2);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || unit_start !== '0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL rst_outputs: got busy=%b start=%b rd=%b wr=%b want 0", busy, unit_start, rd_en, wr_en); end
    total++; if (cmd_count !== 16'd0 || err_code !== 2'd0 || op_a !== '0 || op_b !== '0) begin bad++; $display("FAIL rst_regs: got cnt=%0d code=%0d a=%0h b=%0h want 0", cmd_count, err_code, op_a, op_b); end
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    sb = start_log.size();
    wb = out_q.size();
    push_cmd(48'h0300_0000_0000, 48'd11, 48'd12);
    wait_start(sb, 50, ok);
    total++; if (!ok || start_log[sb] !== 4'b1000 || start_a !== 48'd11) begin bad++; $display("FAIL rst_restart: got ok=%b a=%0h want 1 b", ok, start_a); end
    pulse_done(3, 1'b0, {48'd0, 48'd23}, dcyc);
    wait_writes(wb + 1, 30, ok);
    wait_cycles(2);
    total++; if (!ok || out_q[wb] !== 48'd23) begin bad++; $display("FAIL rst_data: got %0h want 17", ok ? out_q[wb] : 48'd0); end
    total++; if (cmd_count !== 16'd1) begin bad++; $display("FAIL rst_count: got %0d want 1", cmd_count); end
    $display("reset_in_wait: cmd_count=%0d", cmd_count);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_add();
    test_bad_opcode();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
